// File: rtl/mining_ctrl_param.sv
// mining_ctrl_param: nonce-search controller between the block-header BRAM and a SHA-256 core.
// Latency: start to first chunk_valid is 5 cycles; each attempt takes 2 + 3*N + hash wait + 1 cycles.
// Backpressure: chunk_out is held with chunk_valid high until chunk_ready; HWAIT waits on hash_valid_i.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   start_i, abort_i    launch a search from IDLE / cancel a running search
//   num_chunks_i, nonce_addr_i, nonce_lsb_i, zero_bits_i, max_tries_i
//                       search configuration, latched when a start is accepted
//   mem_*               BRAM port with 1-cycle read latency
//   chunk_*             header chunk stream to the hash core (valid/ready)
//   hash_in_i, hash_valid_i   digest returned by the hash core
//   busy_o, found_o, exhausted_o, nonce_out_o, tries_o   search status
module mining_ctrl_param #(
  parameter int CHUNK_W    = 512,
  parameter int ADDR_W     = 16,
  parameter int NONCE_W    = 32,
  parameter int HASH_W     = 256,
  parameter int MAX_CHUNKS = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [$clog2(MAX_CHUNKS):0]   num_chunks_i,
  input  logic [ADDR_W-1:0]             nonce_addr_i,
  input  logic [$clog2(CHUNK_W)-1:0]    nonce_lsb_i,
  input  logic [$clog2(HASH_W):0]       zero_bits_i,
  input  logic [31:0]                   max_tries_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_rd_en_o,
  output logic                          mem_wr_en_o,
  output logic [CHUNK_W-1:0]            mem_wdata_o,
  input  logic [CHUNK_W-1:0]            mem_rdata_i,
  output logic [CHUNK_W-1:0]            chunk_out_o,
  output logic                          chunk_valid_o,
  input  logic                          chunk_ready_i,
  output logic                          chunk_first_o,
  output logic                          chunk_last_o,
  input  logic [HASH_W-1:0]             hash_in_i,
  input  logic                          hash_valid_i,
  output logic                          busy_o,
  output logic                          found_o,
  output logic                          exhausted_o,
  output logic [NONCE_W-1:0]            nonce_out_o,
  output logic [31:0]                   tries_o
);

  localparam int IDX_W = $clog2(MAX_CHUNKS) + 1;
  localparam int LSB_W = $clog2(CHUNK_W);
  localparam int ZB_W  = $clog2(HASH_W) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_NRD, S_NWR, S_CRD, S_CCAP, S_CSEND, S_HWAIT, S_CHECK, S_DONE
  } state_t;

  state_t state_q, state_d;

  // Search configuration captured at start
  logic [IDX_W-1:0]   num_chunks_q;
  logic [ADDR_W-1:0]  nonce_addr_q;
  logic [LSB_W-1:0]   nonce_lsb_q;
  logic [ZB_W-1:0]    zero_bits_q;
  logic [31:0]        max_tries_q;

  // Working registers
  logic [IDX_W-1:0]   index_q;
  logic [NONCE_W-1:0] cur_nonce_q;
  logic [CHUNK_W-1:0] chunk_q;
  logic [HASH_W-1:0]  hash_q;
  logic               found_q;
  logic               exhausted_q;
  logic [NONCE_W-1:0] nonce_out_q;
  logic [31:0]        tries_q;

  logic               start_go;
  logic               is_last;
  logic [NONCE_W-1:0] nonce_inc;
  logic [CHUNK_W-1:0] fld_mask;
  logic [CHUNK_W-1:0] wdata_inc;
  logic [HASH_W-1:0]  hit_mask;
  logic               hit;
  logic [31:0]        tries_inc;
  logic               limit;

  assign start_go  = start_i && !abort_i && (num_chunks_i != '0);
  assign is_last   = (index_q == num_chunks_q - 1'b1);

  // Read-modify-write of the nonce field. mem_rdata_i is the BRAM output register
  // loaded by the NRD read, so this is a register-to-register path.
  assign nonce_inc = NONCE_W'(mem_rdata_i >> nonce_lsb_q) + 1'b1;
  assign fld_mask  = {{(CHUNK_W-NONCE_W){1'b0}}, {NONCE_W{1'b1}}} << nonce_lsb_q;
  assign wdata_inc = (mem_rdata_i & ~fld_mask) | (CHUNK_W'(nonce_inc) << nonce_lsb_q);

  // Mask of the top min(zero_bits, HASH_W) digest bits; an empty mask always hits
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < HASH_W; i++) begin
      if (i < int'(zero_bits_q)) hit_mask[HASH_W-1-i] = 1'b1;
    end
  end

  assign hit       = ((hash_q & hit_mask) == '0);
  assign tries_inc = tries_q + 32'd1;
  assign limit     = (max_tries_q != 32'd0) && (tries_inc == max_tries_q);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start_go) state_d = S_NRD;
        S_NRD:   state_d = S_NWR;
        S_NWR:   state_d = S_CRD;
        S_CRD:   state_d = S_CCAP;
        S_CCAP:  state_d = S_CSEND;
        S_CSEND: if (chunk_ready_i) state_d = is_last ? S_HWAIT : S_CRD;
        S_HWAIT: if (hash_valid_i) state_d = S_CHECK;
        S_CHECK: state_d = (hit || limit) ? S_DONE : S_NRD;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register and internal registers only
  always_comb begin
    busy_o        = (state_q != S_IDLE);
    mem_rd_en_o   = (state_q == S_NRD) || (state_q == S_CRD);
    mem_wr_en_o   = (state_q == S_NWR);
    mem_wdata_o   = (state_q == S_NWR) ? wdata_inc : '0;
    chunk_valid_o = (state_q == S_CSEND);
    chunk_first_o = (state_q == S_CSEND) && (index_q == '0);
    chunk_last_o  = (state_q == S_CSEND) && is_last;
    unique case (state_q)
      S_NRD, S_NWR: mem_addr_o = nonce_addr_q;
      S_CRD:        mem_addr_o = ADDR_W'(index_q);
      default:      mem_addr_o = '0;
    endcase
    chunk_out_o   = chunk_q;
    found_o       = found_q;
    exhausted_o   = exhausted_q;
    nonce_out_o   = nonce_out_q;
    tries_o       = tries_q;
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      num_chunks_q <= '0;
      nonce_addr_q <= '0;
      nonce_lsb_q  <= '0;
      zero_bits_q  <= '0;
      max_tries_q  <= '0;
      index_q      <= '0;
      cur_nonce_q  <= '0;
      chunk_q      <= '0;
      hash_q       <= '0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      nonce_out_q  <= '0;
      tries_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_go) begin
            num_chunks_q <= num_chunks_i;
            nonce_addr_q <= nonce_addr_i;
            nonce_lsb_q  <= nonce_lsb_i;
            zero_bits_q  <= zero_bits_i;
            max_tries_q  <= max_tries_i;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            tries_q      <= '0;
          end
        end
        S_NWR: begin
          cur_nonce_q <= nonce_inc;
          index_q     <= '0;
        end
        S_CCAP:  chunk_q <= mem_rdata_i;
        S_CSEND: if (chunk_ready_i && !is_last) index_q <= index_q + 1'b1;
        S_HWAIT: if (hash_valid_i) hash_q <= hash_in_i;
        S_CHECK: begin
          // An abort in CHECK must leave the result flags clear
          if (!abort_i) begin
            tries_q <= tries_inc;
            if (hit) begin
              nonce_out_q <= cur_nonce_q;
              found_q     <= 1'b1;
            end else if (limit) begin
              exhausted_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mining_ctrl_param.sv
module tb_mining_ctrl_param;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_i, abort_i;
  logic [4:0]    num_chunks_i;
  logic [15:0]   nonce_addr_i;
  logic [8:0]    nonce_lsb_i;
  logic [8:0]    zero_bits_i;
  logic [31:0]   max_tries_i;
  logic [15:0]   mem_addr_o;
  logic          mem_rd_en_o, mem_wr_en_o;
  logic [511:0]  mem_wdata_o;
  logic [511:0]  mem_rdata_i;
  logic [511:0]  chunk_out_o;
  logic          chunk_valid_o, chunk_ready_i, chunk_first_o, chunk_last_o;
  logic [255:0]  hash_in_i;
  logic          hash_valid_i;
  logic          busy_o, found_o, exhausted_o;
  logic [31:0]   nonce_out_o, tries_o;

  mining_ctrl_param dut (
    .clock(clock), .reset(reset), .start_i(start_i), .abort_i(abort_i),
    .num_chunks_i(num_chunks_i), .nonce_addr_i(nonce_addr_i), .nonce_lsb_i(nonce_lsb_i),
    .zero_bits_i(zero_bits_i), .max_tries_i(max_tries_i),
    .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .chunk_out_o(chunk_out_o), .chunk_valid_o(chunk_valid_o), .chunk_ready_i(chunk_ready_i),
    .chunk_first_o(chunk_first_o), .chunk_last_o(chunk_last_o),
    .hash_in_i(hash_in_i), .hash_valid_i(hash_valid_i),
    .busy_o(busy_o), .found_o(found_o), .exhausted_o(exhausted_o),
    .nonce_out_o(nonce_out_o), .tries_o(tries_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] dat;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] bram    [16];
  logic [511:0] ref_mem [16];
  logic [255:0] hash_val;
  int           hash_delay = 0;
  int           ready_mode = 0;   // 0: always ready, 1: random, 2: never
  int           acc_cnt = 0;
  int           n_total = 0;
  int           n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // BRAM model: 1-cycle read latency, write on the strobed edge
  initial begin
    logic         rd, wr;
    logic [3:0]   a;
    logic [511:0] wd;
    mem_rdata_i = '0;
    forever begin
      @(negedge clock);
      rd = mem_rd_en_o; wr = mem_wr_en_o; a = mem_addr_o[3:0]; wd = mem_wdata_o;
      @(posedge clock); #1;
      if (wr) bram[a] = wd;
      if (rd) mem_rdata_i = bram[a];
    end
  end

  // Hash core model: ready driver and digest responder
  initial begin
    chunk_ready_i = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       chunk_ready_i = 1'b1;
        1:       chunk_ready_i = 1'($urandom_range(0, 1));
        default: chunk_ready_i = 1'b0;
      endcase
    end
  end

  initial begin
    hash_valid_i = 1'b0;
    hash_in_i    = '0;
    forever begin
      @(negedge clock);
      if (chunk_valid_o && chunk_ready_i && chunk_last_o) begin
        @(posedge clock);
        repeat (hash_delay) @(posedge clock);
        #1; hash_valid_i = 1'b1; hash_in_i = hash_val;
        @(posedge clock);
        #1; hash_valid_i = 1'b0;
      end
    end
  end

  // Chunk monitor: scoreboard pop on handshake, hold check under backpressure
  initial begin
    logic         stall = 1'b0;
    logic [511:0] stall_dat = '0;
    exp_t         e;
    forever begin
      @(negedge clock);
      chk("rd_wr_excl", {511'd0, mem_rd_en_o & mem_wr_en_o}, 512'd0);
      if (stall && chunk_valid_o) chk("chunk_stable", chunk_out_o, stall_dat);
      if (chunk_valid_o && chunk_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_chunk", 512'd1, 512'd0);
        end else begin
          e = exp_q.pop_front();
          chk("chunk_dat", chunk_out_o, e.dat);
          chk("chunk_first", {511'd0, chunk_first_o}, {511'd0, e.first});
          chk("chunk_last", {511'd0, chunk_last_o}, {511'd0, e.last});
        end
        acc_cnt++;
      end
      stall     = chunk_valid_o && !chunk_ready_i;
      stall_dat = chunk_out_o;
    end
  end

  task automatic init_mem();
    for (int l = 0; l < 16; l++) begin
      for (int w = 0; w < 16; w++) bram[l][w*32 +: 32] = $urandom;
      ref_mem[l] = bram[l];
    end
  endtask

  task automatic set_nonce(input int a, input int lsb, input logic [31:0] v);
    bram[a][lsb +: 32]    = v;
    ref_mem[a][lsb +: 32] = v;
  endtask

  // Model one attempt: bump the nonce in the reference image, queue the header lines
  task automatic push_attempt(input int nch, input int naddr, input int lsb);
    exp_t e;
    ref_mem[naddr][lsb +: 32] = ref_mem[naddr][lsb +: 32] + 32'd1;
    for (int i = 0; i < nch; i++) begin
      e.dat = ref_mem[i]; e.first = (i == 0); e.last = (i == nch - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start_i = 1'b1;
    @(posedge clock); #1 start_i = 1'b0;
    // Scramble configuration inputs: the search must use the latched copies
    num_chunks_i = 5'd1; nonce_addr_i = 16'd7; nonce_lsb_i = 9'd0;
    zero_bits_i = 9'd0; max_tries_i = 32'd1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 3000) begin
      @(negedge clock); n++;
    end
    chk(tag, {511'd0, busy_o}, 512'd0);
  endtask

  task automatic run(input int nch, input int naddr, input int lsb, input int zb,
                     input int maxt, input int attempts, input bit lat);
    int n;
    for (int i = 0; i < attempts; i++) push_attempt(nch, naddr, lsb);
    num_chunks_i = 5'(nch); nonce_addr_i = 16'(naddr); nonce_lsb_i = 9'(lsb);
    zero_bits_i = 9'(zb); max_tries_i = 32'(maxt);
    pulse_start();
    if (lat) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!chunk_valid_o && n < 20);
      chk("start_to_valid", 512'(n), 512'd5);
    end else begin
      @(negedge clock);
      chk("busy_after_start", {511'd0, busy_o}, 512'd1);
    end
    wait_idle("search_timeout");
    chk("queue_drained", 512'(exp_q.size()), 512'd0);
  endtask

  initial begin
    logic [511:0] line, orig;
    int           n;
    reset = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    num_chunks_i = '0; nonce_addr_i = '0; nonce_lsb_i = '0; zero_bits_i = '0; max_tries_i = '0;
    hash_val = '0;
    init_mem();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ctl", {505'd0, mem_rd_en_o, mem_wr_en_o, chunk_valid_o, chunk_first_o,
                    chunk_last_o, busy_o, found_o}, 512'd0);
    chk("rst_addr", {496'd0, mem_addr_o}, 512'd0);
    chk("rst_wdata", mem_wdata_o, 512'd0);
    chk("rst_chunk", chunk_out_o, 512'd0);
    chk("rst_stat", {447'd0, exhausted_o, nonce_out_o, tries_o}, 512'd0);
    @(posedge clock); #1 reset = 1'b1;

    // 1: single-attempt hit, 18 leading zeros against 16 required
    set_nonce(3, 480, 32'h10);
    hash_val = {24'h00003F, {232{1'b1}}}; hash_delay = 2; ready_mode = 0;
    run(4, 3, 480, 16, 0, 1, 1'b1);
    line = bram[3];
    chk("t1_found", {511'd0, found_o}, 512'd1);
    chk("t1_exh", {511'd0, exhausted_o}, 512'd0);
    chk("t1_nonce_out", {480'd0, nonce_out_o}, {480'd0, 32'h11});
    chk("t1_tries", {480'd0, tries_o}, 512'd1);
    chk("t1_mem_field", {480'd0, line[511:480]}, {480'd0, 32'h11});
    chk("t1_mem_line", line, ref_mem[3]);

    // 2: attempt limit with 20 zeros required
    init_mem(); set_nonce(3, 480, 32'h10); hash_delay = 0;
    run(4, 3, 480, 20, 5, 5, 1'b0);
    line = bram[3];
    chk("t2_found", {511'd0, found_o}, 512'd0);
    chk("t2_exh", {511'd0, exhausted_o}, 512'd1);
    chk("t2_tries", {480'd0, tries_o}, 512'd5);
    chk("t2_mem_field", {480'd0, line[511:480]}, {480'd0, 32'h15});

    // 3: nonce wrap with zero_bits=0, field away from the line edges
    init_mem(); set_nonce(3, 100, 32'hFFFF_FFFF); orig = bram[3];
    run(4, 3, 100, 0, 0, 1, 1'b0);
    line = bram[3]; orig[100 +: 32] = 32'h0;
    chk("t3_found", {511'd0, found_o}, 512'd1);
    chk("t3_nonce_out", {480'd0, nonce_out_o}, 512'd0);
    chk("t3_line", line, orig);

    // 4: random backpressure, two attempts ending on the limit
    init_mem(); set_nonce(2, 7, 32'h1234_5678); ready_mode = 1; hash_delay = 3;
    run(4, 2, 7, 20, 2, 2, 1'b0);
    chk("t4_exh", {511'd0, exhausted_o}, 512'd1);
    chk("t4_tries", {480'd0, tries_o}, 512'd2);
    chk("t4_line", bram[2], ref_mem[2]);

    // 5: abort in CSEND of chunk 2, then a fresh search
    init_mem(); set_nonce(3, 480, 32'h20); ready_mode = 0; hash_delay = 1;
    push_attempt(4, 3, 480);
    num_chunks_i = 5'd4; nonce_addr_i = 16'd3; nonce_lsb_i = 9'd480;
    zero_bits_i = 9'd0; max_tries_i = 32'd0; acc_cnt = 0;
    pulse_start();
    n = 0;
    do begin @(posedge clock); #2; n++; end while (!(chunk_valid_o && acc_cnt == 2) && n < 100);
    chk("t5_reach_chunk2", 512'(n < 100), 512'd1);
    abort_i = 1'b1; ready_mode = 2; chunk_ready_i = 1'b0;
    @(posedge clock); #1 abort_i = 1'b0;
    @(negedge clock);
    chk("t5_idle", {509'd0, busy_o, chunk_valid_o, mem_rd_en_o}, 512'd0);
    chk("t5_flags", {510'd0, found_o, exhausted_o}, 512'd0);
    chk("t5_left", 512'(exp_q.size()), 512'd2);
    exp_q.delete();
    line = bram[3];
    chk("t5_write_stood", {480'd0, line[511:480]}, {480'd0, 32'h21});
    ready_mode = 0;
    run(4, 3, 480, 0, 0, 1, 1'b0);
    chk("t5_restart_nonce", {480'd0, nonce_out_o}, {480'd0, 32'h22});
    chk("t5_restart_found", {511'd0, found_o}, 512'd1);

    // 6: start with num_chunks=0 is ignored and does not clear results
    num_chunks_i = 5'd0;
    @(posedge clock); #1 start_i = 1'b1;
    @(posedge clock); #1 start_i = 1'b0;
    @(negedge clock);
    chk("t6_busy", {511'd0, busy_o}, 512'd0);
    repeat (3) @(negedge clock);
    chk("t6_busy_later", {510'd0, busy_o, mem_rd_en_o}, 512'd0);
    chk("t6_found_held", {511'd0, found_o}, 512'd1);

    // 7: reset while waiting for the digest
    init_mem(); set_nonce(3, 480, 32'h40); hash_delay = 40;
    push_attempt(4, 3, 480);
    num_chunks_i = 5'd4; nonce_addr_i = 16'd3; nonce_lsb_i = 9'd480;
    zero_bits_i = 9'd0; max_tries_i = 32'd0; acc_cnt = 0;
    pulse_start();
    n = 0;
    do begin @(posedge clock); #2; n++; end while (!(acc_cnt == 4 && busy_o && !chunk_valid_o) && n < 100);
    chk("t7_reach_hwait", 512'(n < 100), 512'd1);
    reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("t7_ctl", {505'd0, mem_rd_en_o, mem_wr_en_o, chunk_valid_o, chunk_first_o,
                   chunk_last_o, busy_o, found_o}, 512'd0);
    chk("t7_addr", {496'd0, mem_addr_o}, 512'd0);
    chk("t7_wdata", mem_wdata_o, 512'd0);
    chk("t7_chunk", chunk_out_o, 512'd0);
    chk("t7_stat", {447'd0, exhausted_o, nonce_out_o, tries_o}, 512'd0);
    repeat (50) @(negedge clock);
    chk("t7_stray_hash", {510'd0, busy_o, found_o}, 512'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
